// File: rtl/per2apb_pkg.sv
// Shared types and constants for the peripheral-interconnect to APB bridge.
package per2apb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } state_e;

    localparam logic OPC_OK  = 1'b0;
    localparam logic OPC_ERR = 1'b1;

endpackage

// File: rtl/per2apb.sv
// Replays single-word peripheral-interconnect requests as APB3/APB4 transfers,
// one outstanding transaction at a time.
module per2apb
    import per2apb_pkg::*;
#(
    parameter int unsigned PER_ADDR_WIDTH = 32,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned PER_ID_WIDTH   = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      per_slave_req_i,
    input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
    input  logic                      per_slave_we_i,
    input  logic [31:0]               per_slave_wdata_i,
    input  logic [3:0]                per_slave_be_i,
    input  logic [PER_ID_WIDTH-1:0]   per_slave_id_i,
    output logic                      per_slave_gnt_o,

    output logic                      per_slave_r_valid_o,
    output logic                      per_slave_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
    output logic [31:0]               per_slave_r_rdata_o,

    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic [3:0]                PSTRB,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    if (APB_ADDR_WIDTH > PER_ADDR_WIDTH) begin : g_addr_width_check
        $error("per2apb: APB_ADDR_WIDTH must not exceed PER_ADDR_WIDTH");
    end

    state_e                    r_state;
    state_e                    w_state_next;

    logic [APB_ADDR_WIDTH-1:0] r_addr;
    logic                      r_we;
    logic [31:0]               r_wdata;
    logic [3:0]                r_be;
    logic [PER_ID_WIDTH-1:0]   r_id;

    logic                      r_rvalid;
    logic                      r_ropc;
    logic [PER_ID_WIDTH-1:0]   r_rid;
    logic [31:0]               r_rdata;

    logic                      w_req_accept;
    logic                      w_rsp_done;

    assign w_req_accept = (r_state == StIdle) && per_slave_req_i;
    // PREADY only counts in ACCESS, so a ready slave during SETUP is ignored.
    assign w_rsp_done   = (r_state == StAccess) && PREADY;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (per_slave_req_i) w_state_next = StSetup;
            StSetup:  w_state_next = StAccess;
            StAccess: if (PREADY) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        per_slave_gnt_o = 1'b0;
        PSEL            = 1'b0;
        PENABLE         = 1'b0;
        unique case (r_state)
            StIdle:   per_slave_gnt_o = per_slave_req_i;
            StSetup:  PSEL = 1'b1;
            StAccess: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_id     <= '0;
            r_rvalid <= 1'b0;
            r_ropc   <= OPC_OK;
            r_rid    <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_req_accept) begin
                r_addr  <= per_slave_add_i[APB_ADDR_WIDTH-1:0];
                r_we    <= per_slave_we_i;
                r_wdata <= per_slave_wdata_i;
                r_be    <= per_slave_be_i;
                r_id    <= per_slave_id_i;
            end
            r_rvalid <= w_rsp_done;
            if (w_rsp_done) begin
                r_rdata <= r_we ? 32'h0 : PRDATA;
                r_ropc  <= PSLVERR ? OPC_ERR : OPC_OK;
                r_rid   <= r_id;
            end
        end
    end

    assign PADDR  = r_addr;
    assign PWDATA = r_wdata;
    assign PWRITE = r_we;
    assign PSTRB  = r_we ? r_be : 4'b0000;

    assign per_slave_r_valid_o = r_rvalid;
    assign per_slave_r_opc_o   = r_ropc;
    assign per_slave_r_id_o    = r_rid;
    assign per_slave_r_rdata_o = r_rdata;

endmodule

// File: doc/per2apb.md
# per2apb

Bridges the peripheral interconnect to APB: a peripheral-interconnect slave port accepts single-word requests and replays each as one APB3/APB4 transfer on an APB master port. The response is returned on the peripheral response channel. It sits between the cluster peripheral interconnect and an APB subsystem of timers, GPIO and UART, as the initiator-side counterpart of the APB-to-peripheral adapter. Exactly one transaction is outstanding at a time.

## Interface
- PER_ADDR_WIDTH, 32, peripheral-side address width
- APB_ADDR_WIDTH, 32, APB address width; must be ≤ PER_ADDR_WIDTH
- PER_ID_WIDTH, 5, transaction ID width, echoed on response
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  asynchronous reset, active low
- per_slave_req_i  in  1  request valid
- per_slave_add_i  in  PER_ADDR_WIDTH  byte address
- per_slave_we_i  in  1  1 = write, 0 = read
- per_slave_wdata_i  in  32  write data
- per_slave_be_i  in  4  byte enables
- per_slave_id_i  in  PER_ID_WIDTH  transaction ID
- per_slave_gnt_o  out  1  request accepted this cycle
- per_slave_r_valid_o  out  1  response valid, one-cycle pulse
- per_slave_r_opc_o  out  1  0 = OK, 1 = error (PSLVERR)
- per_slave_r_id_o  out  PER_ID_WIDTH  ID of the completed request
- per_slave_r_rdata_o  out  32  read data; 0 for writes
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSTRB  out  4  APB4 write strobes
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - per_slave_gnt_o = per_slave_req_i (combinational, only in IDLE).
  - On gnt, register the request: add[APB_ADDR_WIDTH-1:0], we, wdata, be and id. Go to SETUP.
- **SETUP**
  - PSEL=1, PENABLE=0.
  - APB address/data/control outputs are driven from the registered request.
  - Always go to ACCESS next cycle.
- **ACCESS**
  - PSEL=1, PENABLE=1; outputs held stable.
  - PREADY=0: stay in ACCESS. There is no timeout.
  - PREADY=1: register the response and go to IDLE.
    - r_rdata = we ? 0 : PRDATA.
    - r_opc = PSLVERR.
    - r_id = registered id.
    - Set the r_valid flop.
- **Response**
  - per_slave_r_valid_o is a registered pulse, high exactly one cycle: the cycle after PREADY was sampled.
  - r_rdata, r_opc and r_id hold their values until the next completion.
- **Other rules**
  - PSTRB = registered be for writes; 4'b0000 for reads.
  - PWDATA is a don't-care for reads but is driven from the register.
  - per_slave_gnt_o = 0 in SETUP and ACCESS. A pending req stays pending; the bridge neither drops nor buffers it.
- **Reset**
  - All outputs are 0 at reset.
  - FSM goes to IDLE; request and response registers are cleared.
  - Reset asserted mid-transfer deasserts PSEL/PENABLE immediately (asynchronous). No response is generated for the aborted transaction.

## Timing
- Cycle 0: req=1 in IDLE → gnt=1.
- Cycle 1: SETUP.
- Cycle 2: ACCESS; if PREADY=1 the transfer completes.
- Cycle 3: r_valid=1; FSM already in IDLE, so gnt for the next request may coincide with r_valid.
- Minimum latency gnt→r_valid: 3 cycles. Each APB wait state adds 1 cycle.
- Peak throughput: one transaction per 3 cycles.
- Boundary conditions:
  - PREADY high during SETUP is ignored.
  - PSLVERR is sampled only when PENABLE & PREADY.
  - Address bits above APB_ADDR_WIDTH are discarded with no check.

## Structure
- Package per2apb_pkg holds:
  - state enum typedef (2-bit, IDLE/SETUP/ACCESS);
  - response opcode constants OPC_OK=1'b0, OPC_ERR=1'b1.
- Single flat module per2apb: FSM, request register, response register. No sub-module is needed.
- Elaboration-time assertion: APB_ADDR_WIDTH ≤ PER_ADDR_WIDTH.

## Test plan
- **Write, zero wait:** req we=1 add=0x1A10_2004 wdata=0xDEADBEEF be=0xF id=3. Required: gnt same cycle; SETUP with PADDR=0x1A10_2004, PSTRB=0xF, PENABLE=0; ACCESS with PREADY=1; r_valid 3 cycles after gnt with opc=0, id=3, rdata=0.
- **Read, 2 wait states:** PREADY low 2 ACCESS cycles, then PRDATA=0x1234_5678. Required: PENABLE high 3 cycles; PSTRB=0; r_valid at gnt+5 with rdata=0x1234_5678, id echoed.
- **Error:** read completes with PSLVERR=1. Required: r_opc=1 for the single r_valid cycle; FSM returns to IDLE.
- **Back-to-back:** req held high for 3 transfers with IDs 1,2,3. Required: gnt only in IDLE cycles, spaced 3 cycles apart; each r_valid coincides with the next gnt; IDs return in order; PSEL never deasserts mid-transfer.
- **Partial write:** be=4'b0100. Required: PSTRB=4'b0100 through SETUP and ACCESS.
- **Reset mid-access:** assert rst_ni=0 while in ACCESS with PREADY=0. Required: PSEL, PENABLE and r_valid are 0 immediately; after release, no stale r_valid appears and the next request completes normally.
